univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 139 +++++++++++++
 tb/tb_univ_shift_reg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load/clear/hold in a single cycle,
// multi-cycle shift/rotate executed as N single-bit steps with busy/done handshake.
module univ_shift_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           AMT_W     = 6,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             ser_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] shift_q_d;
    logic             shift_ser_d;

    // One-bit step of the latched shift operation applied to the current register value
    always_comb begin
        shift_q_d   = q_q;
        shift_ser_d = ser_q;
        case (op_q)
            OP_SHL: begin
                shift_q_d   = {q_q[WIDTH-2:0], ser_in};
                shift_ser_d = q_q[WIDTH-1];
            end
            OP_SHR: begin
                shift_q_d   = {ser_in, q_q[WIDTH-1:1]};
                shift_ser_d = q_q[0];
            end
            OP_ROL: begin
                shift_q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                shift_ser_d = q_q[WIDTH-1];
            end
            OP_ROR: begin
                shift_q_d   = {q_q[0], q_q[WIDTH-1:1]};
                shift_ser_d = q_q[0];
            end
            OP_ASR: begin
                shift_q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                shift_ser_d = q_q[0];
            end
            default: begin
                shift_q_d   = q_q;
                shift_ser_d = ser_q;
            end
        endcase
    end

    // Control FSM and datapath registers; done is a single-cycle pulse by default-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_HOLD: begin
                                done_q <= 1'b1;
                            end
                            OP_LOAD: begin
                                q_q    <= d_in;
                                done_q <= 1'b1;
                            end
                            OP_CLEAR: begin
                                q_q    <= '0;
                                done_q <= 1'b1;
                            end
                            default: begin
                                // Zero-length shift completes immediately without touching q
                                if (amt == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q <= SHIFT;
                                    busy_q  <= 1'b1;
                                    op_q    <= op;
                                    cnt_q   <= amt;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    q_q   <= shift_q_d;
                    ser_q <= shift_ser_d;
                    cnt_q <= cnt_q - AMT_W'(1);
                    // Last step: count reaches zero here, never wraps below it
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign q       = q_q;
    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_univ_shift_reg;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 4;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          start  = 1'b0;
    logic [2:0]    op     = 3'd0;
    logic [AW-1:0] amt    = '0;
    logic [W-1:0]  d_in   = '0;
    logic          ser_in = 1'b0;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_q;
    logic         m_ser;
    logic         m_busy;
    logic         m_done;
    int           m_rem;
    logic [2:0]   m_op;

    logic [W-1:0] rol_seq  [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
    logic         rol_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    univ_shift_reg #(
        .WIDTH    (W),
        .AMT_W    (AW),
        .RESET_VAL(8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .d_in   (d_in),
        .ser_in (ser_in),
        .q      (q),
        .ser_out(ser_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One single-bit step expressed as integer arithmetic: returns {ser_out, q}
    function automatic logic [8:0] step_val(input logic [2:0] o, input logic [W-1:0] v, input logic si);
        int iv;
        int nq;
        int ns;
        iv = int'(v);
        nq = iv;
        ns = 0;
        case (o)
            3'd2: begin nq = (iv * 2 + int'(si)) % 256;        ns = iv / 128; end
            3'd3: begin nq = int'(si) * 128 + iv / 2;          ns = iv % 2;   end
            3'd4: begin nq = (iv * 2) % 256 + iv / 128;        ns = iv / 128; end
            3'd5: begin nq = (iv % 2) * 128 + iv / 2;          ns = iv % 2;   end
            3'd6: begin nq = (iv / 128) * 128 + iv / 2;        ns = iv % 2;   end
            default: begin nq = iv; ns = 0; end
        endcase
        return {1'(ns), 8'(nq)};
    endfunction

    // Reference model: remaining-step counter plus arithmetic step function
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= 8'h00;
            m_ser  <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
            m_op   <= 3'd0;
        end else if (m_busy) begin
            logic [8:0] r;
            r = step_val(m_op, m_q, ser_in);
            m_q   <= r[7:0];
            m_ser <= r[8];
            m_rem <= m_rem - 1;
            m_done <= (m_rem == 1);
            m_busy <= (m_rem != 1);
        end else begin
            m_done <= 1'b0;
            if (start) begin
                case (op)
                    3'd0: m_done <= 1'b1;
                    3'd1: begin m_q <= d_in;  m_done <= 1'b1; end
                    3'd7: begin m_q <= 8'h00; m_done <= 1'b1; end
                    default: begin
                        if (amt == 0) begin
                            m_done <= 1'b1;
                        end else begin
                            m_busy <= 1'b1;
                            m_rem  <= int'(amt);
                            m_op   <= op;
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q",    32'(q),       32'(m_q));
            chk("model_ser",  32'(ser_out), 32'(m_ser));
            chk("model_busy", 32'(busy),    32'(m_busy));
            chk("model_done", 32'(done),    32'(m_done));
            chk("busy_done_excl", 32'(busy & done), 32'(0));
        end
    end

    task automatic go(input logic [2:0] o, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic s, input bit sync);
        if (sync) @(negedge clk);
        #1;
        op     = o;
        amt    = a;
        d_in   = d;
        ser_in = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'(1));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_q",    32'(q),       32'h00);
        chk("rst_ser",  32'(ser_out), 32'(0));
        chk("rst_busy", 32'(busy),    32'(0));
        chk("rst_done", 32'(done),    32'(0));
        #1 rst = 1'b0;

        // LOAD A5 in one edge
        go(3'd1, 4'd0, 8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        chk("load_q",    32'(q),    32'hA5);
        chk("load_done", 32'(done), 32'(1));
        chk("load_busy", 32'(busy), 32'(0));

        // ROL 3 from 81
        go(3'd1, 4'd0, 8'h81, 1'b0, 1'b1);
        wait_done();
        go(3'd4, 4'd3, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rol_q",    32'(q),    32'(rol_seq[k]));
            chk("rol_busy", 32'(busy), 32'(rol_busy[k]));
        end
        chk("rol_done", 32'(done),    32'(1));
        chk("rol_ser",  32'(ser_out), 32'(0));

        // ASR 9 from 80 saturates to FF, then SHR 2
        go(3'd1, 4'd0, 8'h80, 1'b0, 1'b1);
        wait_done();
        go(3'd6, 4'd9, 8'h00, 1'b0, 1'b1);
        wait_done();
        chk("asr_q", 32'(q), 32'hFF);
        go(3'd3, 4'd2, 8'h00, 1'b0, 1'b1);
        wait_done();
        chk("shr_q",   32'(q),       32'h3F);
        chk("shr_ser", 32'(ser_out), 32'(1));

        // SHL 4 from 0F with an ignored LOAD request mid-shift
        go(3'd1, 4'd0, 8'h0F, 1'b0, 1'b1);
        wait_done();
        go(3'd2, 4'd4, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        op    = 3'd1;
        d_in  = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        chk("shl_ign_q",   32'(q),       32'hF0);
        chk("shl_ign_ser", 32'(ser_out), 32'(0));

        // Reset in the middle of SHR 5
        go(3'd1, 4'd0, 8'hC3, 1'b0, 1'b1);
        wait_done();
        go(3'd3, 4'd5, 8'h00, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_q",    32'(q),       32'h00);
        chk("abort_busy", 32'(busy),    32'(0));
        chk("abort_ser",  32'(ser_out), 32'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'(0));
        end
        go(3'd1, 4'd0, 8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_load", 32'(q), 32'h5A);

        // SHL 0 then LOAD issued in the done cycle
        go(3'd1, 4'd0, 8'h3C, 1'b0, 1'b1);
        wait_done();
        go(3'd2, 4'd0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("amt0_q",    32'(q),    32'h3C);
        chk("amt0_done", 32'(done), 32'(1));
        go(3'd1, 4'd0, 8'h99, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_q",    32'(q),    32'h99);
        chk("b2b_done", 32'(done), 32'(1));

        // ROR 1, ROL 8 wraps with inputs scrambled mid-op, SHL 10 fills, CLEAR, HOLD
        go(3'd1, 4'd0, 8'h01, 1'b0, 1'b1);
        wait_done();
        go(3'd5, 4'd1, 8'h00, 1'b0, 1'b1);
        wait_done();
        chk("ror_q",   32'(q),       32'h80);
        chk("ror_ser", 32'(ser_out), 32'(1));
        go(3'd1, 4'd0, 8'hA5, 1'b0, 1'b1);
        wait_done();
        go(3'd4, 4'd8, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        op   = 3'd7;
        amt  = 4'hF;
        d_in = 8'h00;
        wait_done();
        chk("rol8_q", 32'(q), 32'hA5);
        go(3'd2, 4'd10, 8'h00, 1'b1, 1'b1);
        wait_done();
        chk("shl_fill_q", 32'(q), 32'hFF);
        go(3'd7, 4'd0, 8'h00, 1'b0, 1'b1);
        wait_done();
        chk("clear_q", 32'(q), 32'h00);
        go(3'd1, 4'd0, 8'h03, 1'b0, 1'b1);
        wait_done();
        go(3'd0, 4'd0, 8'hEE, 1'b0, 1'b1);
        wait_done();
        chk("hold_q", 32'(q), 32'h03);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
